// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

  // Widest pend vector the popcount helper accepts (ADDR_W up to 8).
  localparam int PC_MAX_W   = 256;

  function automatic int unsigned popcount(input logic [PC_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < PC_MAX_W; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// One read port: zero register, then write bypass (highest port wins), then storage.
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_WR = 1
) (
  input  logic [ADDR_W-1:0]        i_rd_addr,
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
  input  logic [DATA_W-1:0]        i_stor_data,
  input  logic                     i_pend,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_ready
);

  // Later assignments override earlier ones, so the zero check comes last.
  always_comb begin
    o_data  = i_stor_data;
    o_ready = ~i_pend;
    for (int w = 0; w < NUM_WR; w++) begin
      if (i_wr_en[w] && (i_wr_addr[w*ADDR_W +: ADDR_W] == i_rd_addr)) begin
        o_data  = i_wr_data[w*DATA_W +: DATA_W];
        o_ready = 1'b1;
      end
    end
    if (i_rd_addr == ADDR_W'(REG_ZERO)) begin
      o_data  = '0;
      o_ready = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file with write-to-read bypass and a pending-write scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          pending_cnt
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0]   r_regs [NREGS];
  logic [NREGS-1:0]    r_pend;
  logic [ADDR_W:0]     r_pending_cnt;
  logic [NREGS-1:0]    w_wr_hit;
  logic [NREGS-1:0]    w_pend_nxt;
  logic [PC_MAX_W-1:0] w_pend_ext;

  // Ascending port order: the last non-blocking write to an address wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO)))
          r_regs[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_wr_hit = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) w_wr_hit[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b1;
    end
  end

  // An alloc beats a same-cycle writeback: the newly issued producer is younger.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int k = 0; k < NREGS; k++) begin
      if (k == REG_ZERO)                                    w_pend_nxt[k] = 1'b0;
      else if (flush)                                       w_pend_nxt[k] = 1'b0;
      else if (alloc_en && (alloc_addr == ADDR_W'(k)))      w_pend_nxt[k] = 1'b1;
      else if (w_wr_hit[k])                                 w_pend_nxt[k] = 1'b0;
    end
  end

  always_comb begin
    w_pend_ext              = '0;
    w_pend_ext[NREGS-1:0]   = w_pend_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend        <= '0;
      r_pending_cnt <= '0;
    end else begin
      r_pend        <= w_pend_nxt;
      r_pending_cnt <= (ADDR_W+1)'(popcount(w_pend_ext));
    end
  end

  assign pending_cnt = r_pending_cnt;

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    regfile_bypass_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_mux (
      .i_rd_addr   (rd_addr[r*ADDR_W +: ADDR_W]),
      .i_wr_en     (wr_en),
      .i_wr_addr   (wr_addr),
      .i_wr_data   (wr_data),
      .i_stor_data (r_regs[rd_addr[r*ADDR_W +: ADDR_W]]),
      .i_pend      (r_pend[rd_addr[r*ADDR_W +: ADDR_W]]),
      .o_data      (rd_data[r*DATA_W +: DATA_W]),
      .o_ready     (rd_ready[r])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: 2 read ports, 2 write ports, queued expectations.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_ready;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic             flush;
  logic [AW:0]      pending_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;   // 0/1 = read port, 2 = pending_cnt
    logic [31:0] data;
    logic        rdy;
    logic [5:0]  cnt;
  } exp_t;
  exp_t exp_q[$];

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .alloc_en    (alloc_en),
    .alloc_addr  (alloc_addr),
    .flush       (flush),
    .pending_cnt (pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic exp_rd(input int p, input logic [31:0] d, input logic r);
    exp_t e;
    e.kind = p; e.data = d; e.rdy = r; e.cnt = '0;
    exp_q.push_back(e);
  endtask

  task automatic exp_cnt(input logic [5:0] c);
    exp_t e;
    e.kind = 2; e.data = '0; e.rdy = 1'b0; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic sample(input string tag);
    exp_t e;
    logic [31:0] d;
    logic        r;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.kind == 2) begin
        checks++;
        assert (pending_cnt === e.cnt) else begin
          errors++;
          $error("FAIL %s pending_cnt: got %0d expected %0d", tag, pending_cnt, e.cnt);
        end
      end else begin
        d = rd_data[e.kind*DW +: DW];
        r = rd_ready[e.kind];
        checks++;
        assert (d === e.data) else begin
          errors++;
          $error("FAIL %s data%0d: got %h expected %h", tag, e.kind, d, e.data);
        end
        checks++;
        assert (r === e.rdy) else begin
          errors++;
          $error("FAIL %s ready%0d: got %b expected %b", tag, e.kind, r, e.rdy);
        end
      end
    end
  endtask

  task automatic idle();
    wr_en = '0; alloc_en = 1'b0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic alloc(input logic [4:0] a);
    alloc_en = 1'b1; alloc_addr = a;
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; wr_addr = '0; wr_data = '0; alloc_addr = '0;
    idle();
    @(negedge clk);
    // write during reset must be discarded
    wr(0, 5'd5, 32'hDEADBEEF);
    step();
    rst = 1'b0;
    rd(5'd5, 5'd0);
    exp_rd(0, 32'h0, 1'b1); exp_rd(1, 32'h0, 1'b1); exp_cnt(6'd0);
    sample("reset_read");

    // two-port write to r3, port 1 wins both on bypass and in storage
    wr(0, 5'd3, 32'h11111111); wr(1, 5'd3, 32'h22222222);
    rd(5'd3, 5'd5);
    exp_rd(0, 32'h22222222, 1'b1); exp_rd(1, 32'h0, 1'b1);
    sample("bypass_prio");
    step();
    exp_rd(0, 32'h22222222, 1'b1);
    sample("store_prio");

    // alloc r7: same cycle still ready, next cycle pending
    alloc(5'd7); rd(5'd7, 5'd3);
    exp_rd(0, 32'h0, 1'b1); exp_cnt(6'd0);
    sample("alloc_same");
    step();
    exp_rd(0, 32'h0, 1'b0); exp_rd(1, 32'h22222222, 1'b1); exp_cnt(6'd1);
    sample("alloc_next");
    wr(0, 5'd7, 32'hCAFE0007);
    exp_rd(0, 32'hCAFE0007, 1'b1); exp_cnt(6'd1);
    sample("wb_bypass");
    step();
    exp_rd(0, 32'hCAFE0007, 1'b1); exp_cnt(6'd0);
    sample("wb_clear");

    // alloc and write to r9 in one cycle: data lands, bit stays set
    alloc(5'd9); wr(0, 5'd9, 32'h9); rd(5'd9, 5'd7);
    step();
    exp_rd(0, 32'h9, 1'b0); exp_rd(1, 32'hCAFE0007, 1'b1); exp_cnt(6'd1);
    sample("alloc_wr_collide");
    wr(1, 5'd9, 32'h99);
    step();
    exp_rd(0, 32'h99, 1'b1); exp_cnt(6'd0);
    sample("r9_clear");

    // three allocs then flush with a suppressed alloc
    alloc(5'd1); step();
    alloc(5'd2); step();
    alloc(5'd4); step();
    rd(5'd1, 5'd4);
    exp_rd(0, 32'h0, 1'b0); exp_rd(1, 32'h0, 1'b0); exp_cnt(6'd3);
    sample("three_pending");
    flush = 1'b1; alloc(5'd6);
    step();
    rd(5'd1, 5'd6);
    exp_rd(0, 32'h0, 1'b1); exp_rd(1, 32'h0, 1'b1); exp_cnt(6'd0);
    sample("flush");

    // register zero ignores alloc and write
    alloc(5'd5); step();
    alloc(5'd0); wr(1, 5'd0, 32'hFFFFFFFF); rd(5'd0, 5'd5);
    exp_rd(0, 32'h0, 1'b1); exp_rd(1, 32'h0, 1'b0); exp_cnt(6'd1);
    sample("zero_same");
    step();
    exp_rd(0, 32'h0, 1'b1); exp_cnt(6'd1);
    sample("zero_next");

    // mid-run reset clears data and pending state
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd(5'd3, 5'd5);
    exp_rd(0, 32'h0, 1'b1); exp_rd(1, 32'h0, 1'b1); exp_cnt(6'd0);
    sample("mid_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the pipelined MIPS32 core. It replaces the fixed two-read, one-write file and adds:

- N read ports and M write ports, with internal write-to-read bypass.
- A per-register pending-write scoreboard for the decode-stage hazard logic.
- A flush that clears the scoreboard on branch mispredict or exception.

Register 0 is hardwired to zero.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W
- NUM_RD, 2, read ports (1..4)
- NUM_WR, 1, write ports (1..2); a higher index has priority

Ports (port i occupies slice [i*W +: W] of each flattened vector):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  read addresses
- rd_data  out  NUM_RD*DATA_W  read data (combinational)
- rd_ready  out  NUM_RD  1 = rd_data is valid (no unresolved producer)
- wr_en  in  NUM_WR  write enables
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- alloc_en  in  1  decode issues an instruction that will write alloc_addr
- alloc_addr  in  ADDR_W  destination being allocated
- flush  in  1  clear all pending bits
- pending_cnt  out  ADDR_W+1  number of registers currently pending (registered)

## Operation
- Storage: regs[NREGS], pend[NREGS]. Register 0 always reads 0 and is never pending. Writes and allocs to address 0 are ignored.
- Write: for each enabled port with wr_addr≠0, regs[wr_addr] ← wr_data at the edge. If two ports hit the same address, port NUM_WR-1 wins.
- Read, port r, in priority order:
  1. Address 0 → data 0, ready 1.
  2. Any enabled write port matches the address → data from the highest-index matching port, ready 1 (bypass).
  3. Otherwise → data regs[addr], ready = ~pend[addr].
- Scoreboard next-state per register k≠0, in priority order:
  1. rst → 0.
  2. flush → 0. A flush also suppresses a same-cycle alloc; writes still commit.
  3. alloc_en and alloc_addr==k → 1. A same-cycle write to k commits its data but the bit is set, because the new producer is younger.
  4. Any wr_en hitting k → 0.
  5. Otherwise hold.
- Multiple outstanding producers to one register are not tracked. The first writeback clears the bit. Decode must stall WAW hazards; the bench may flag violations with an assertion.
- pending_cnt is the population count of the pend array after the update, registered.

## Timing
- Reset: all regs 0, all pend 0, pending_cnt 0.
  - One cycle after rst is asserted, every rd_data = 0 and every rd_ready = 1, unless a write port is active (bypass is combinational and is not gated by rst).
  - Writes in the cycle rst is high are discarded.
- Read latency is 0 cycles: rd_data and rd_ready are combinational from rd_addr, wr_*, and state.
- A write becomes architecturally visible through storage in the cycle after wr_en, and through bypass in the same cycle.
- An alloc sets the pending bit visible on rd_ready in the next cycle. The alloc does not affect reads in the same cycle.
- pending_cnt reflects the state one cycle after the causing event.
- A flush during an active stall drops all readiness hazards in the following cycle.

## Structure
- Package regfile_pkg:
  - REG_ZERO constant.
  - Default DATA_W and ADDR_W.
  - Popcount function used for pending_cnt.
- Sub-module regfile_bypass_mux, instantiated NUM_RD times. It takes one read address, all write ports, the storage word, and the pend bit, and produces data and ready. It contains the zero/bypass/storage priority chain.
- Top level holds the storage array, scoreboard, write-priority resolution, and popcount register.

## Test plan
- Reset then read: write 0xDEADBEEF to r5 with rst=1, release rst, read r5 → data 0x00000000, ready 1, pending_cnt 0.
- Bypass and priority:
  - Writing r3=0x11111111 (port 0) and r3=0x22222222 (port 1) in one cycle → same-cycle read returns 0x22222222, ready 1.
  - The next-cycle read also returns 0x22222222.
- Scoreboard:
  - alloc r7, then read r7 next cycle → ready 0, pending_cnt 1.
  - Write r7=0xCAFE0007 → same-cycle read returns 0xCAFE0007 with ready 1; the next cycle has ready 1 and pending_cnt 0.
- Alloc/write collision: alloc r9 while writing r9=0x9 → next cycle data 0x9, ready 0, pending_cnt 1.
- Flush: alloc r1, r2, r4 on consecutive cycles (pending_cnt 3), then flush with alloc r6 in the same cycle → next cycle pending_cnt 0 and r6 ready 1.
- Zero register: alloc r0 and write r0=0xFFFFFFFF → r0 reads 0, ready 1, pending_cnt unchanged.
